// File: rtl/cu_pkg.sv
// cu_pkg: Mini SRC opcodes, ctrl strobe bit map, FSM states and instruction classes
package cu_pkg;

    localparam int CTRL_W = 30;
    localparam int OPC_W  = 5;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                                 OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101,
                                 OP_SHRA = 5'b00110, OP_SHL  = 5'b00111, OP_ROR  = 5'b01000,
                                 OP_ROL  = 5'b01001, OP_AND  = 5'b01010, OP_OR   = 5'b01011,
                                 OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                                 OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001,
                                 OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100,
                                 OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                                 OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010,
                                 OP_HALT = 5'b11011;

    localparam logic [OPC_W-1:0] ALU_ADD = OP_ADD;

    localparam int CTRL_PCOUT = 0, CTRL_ZHIGHOUT = 1, CTRL_ZLOWOUT = 2, CTRL_MDROUT = 3,
                   CTRL_HIOUT = 4, CTRL_LOOUT = 5, CTRL_INPORTOUT = 6, CTRL_COUT = 7,
                   CTRL_BAOUT = 8, CTRL_GRA = 9, CTRL_GRB = 10, CTRL_GRC = 11, CTRL_RIN = 12,
                   CTRL_ROUT = 13, CTRL_MARIN = 14, CTRL_MDRIN = 15, CTRL_IRIN = 16,
                   CTRL_PCIN = 17, CTRL_YIN = 18, CTRL_ZIN = 19, CTRL_HIIN = 20, CTRL_LOIN = 21,
                   CTRL_CONIN = 22, CTRL_OUTPORTIN = 23, CTRL_INPORTIN = 24, CTRL_INCPC = 25,
                   CTRL_READ = 26, CTRL_RAM_READ = 27, CTRL_RAM_WRITE = 28, CTRL_ILLEGAL = 29;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t C_PCOUT     = ctrl_t'(1) << CTRL_PCOUT;
    localparam ctrl_t C_ZHIGHOUT  = ctrl_t'(1) << CTRL_ZHIGHOUT;
    localparam ctrl_t C_ZLOWOUT   = ctrl_t'(1) << CTRL_ZLOWOUT;
    localparam ctrl_t C_MDROUT    = ctrl_t'(1) << CTRL_MDROUT;
    localparam ctrl_t C_HIOUT     = ctrl_t'(1) << CTRL_HIOUT;
    localparam ctrl_t C_LOOUT     = ctrl_t'(1) << CTRL_LOOUT;
    localparam ctrl_t C_INPORTOUT = ctrl_t'(1) << CTRL_INPORTOUT;
    localparam ctrl_t C_COUT      = ctrl_t'(1) << CTRL_COUT;
    localparam ctrl_t C_BAOUT     = ctrl_t'(1) << CTRL_BAOUT;
    localparam ctrl_t C_GRA       = ctrl_t'(1) << CTRL_GRA;
    localparam ctrl_t C_GRB       = ctrl_t'(1) << CTRL_GRB;
    localparam ctrl_t C_GRC       = ctrl_t'(1) << CTRL_GRC;
    localparam ctrl_t C_RIN       = ctrl_t'(1) << CTRL_RIN;
    localparam ctrl_t C_ROUT      = ctrl_t'(1) << CTRL_ROUT;
    localparam ctrl_t C_MARIN     = ctrl_t'(1) << CTRL_MARIN;
    localparam ctrl_t C_MDRIN     = ctrl_t'(1) << CTRL_MDRIN;
    localparam ctrl_t C_IRIN      = ctrl_t'(1) << CTRL_IRIN;
    localparam ctrl_t C_PCIN      = ctrl_t'(1) << CTRL_PCIN;
    localparam ctrl_t C_YIN       = ctrl_t'(1) << CTRL_YIN;
    localparam ctrl_t C_ZIN       = ctrl_t'(1) << CTRL_ZIN;
    localparam ctrl_t C_HIIN      = ctrl_t'(1) << CTRL_HIIN;
    localparam ctrl_t C_LOIN      = ctrl_t'(1) << CTRL_LOIN;
    localparam ctrl_t C_CONIN     = ctrl_t'(1) << CTRL_CONIN;
    localparam ctrl_t C_OUTPORTIN = ctrl_t'(1) << CTRL_OUTPORTIN;
    localparam ctrl_t C_INPORTIN  = ctrl_t'(1) << CTRL_INPORTIN;
    localparam ctrl_t C_INCPC     = ctrl_t'(1) << CTRL_INCPC;
    localparam ctrl_t C_READ      = ctrl_t'(1) << CTRL_READ;
    localparam ctrl_t C_RAM_READ  = ctrl_t'(1) << CTRL_RAM_READ;
    localparam ctrl_t C_RAM_WRITE = ctrl_t'(1) << CTRL_RAM_WRITE;
    localparam ctrl_t C_ILLEGAL   = ctrl_t'(1) << CTRL_ILLEGAL;

    typedef enum logic [3:0] {
        ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef enum logic [4:0] {
        CL_ALU3, CL_ALUI, CL_LDI, CL_LD, CL_ST, CL_MULDIV, CL_NEGNOT, CL_BR, CL_JR,
        CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
    } cls_t;

endpackage

// File: rtl/cu_class_decode.sv
// cu_class_decode: opcode to execute class and the T-step on which that class finishes
import cu_pkg::*;

module cu_class_decode (
    input  logic [OPC_W-1:0] opc,
    output cls_t             cls,
    output logic [2:0]       last
);

    // group opcodes that share an identical execute sequence
    always_comb begin
        cls = CL_ILL;
        case (opc)
            OP_LD:   cls = CL_LD;
            OP_LDI:  cls = CL_LDI;
            OP_ST:   cls = CL_ST;
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR:
                     cls = CL_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:
                     cls = CL_ALUI;
            OP_MUL, OP_DIV: cls = CL_MULDIV;
            OP_NEG, OP_NOT: cls = CL_NEGNOT;
            OP_BR:   cls = CL_BR;
            OP_JR:   cls = CL_JR;
            OP_JAL:  cls = CL_JAL;
            OP_IN:   cls = CL_IN;
            OP_OUT:  cls = CL_OUT;
            OP_MFHI: cls = CL_MFHI;
            OP_MFLO: cls = CL_MFLO;
            OP_NOP:  cls = CL_NOP;
            OP_HALT: cls = CL_HALT;
            default: cls = CL_ILL;
        endcase
    end

    // final execute step per class; every class ends at or before T7
    always_comb begin
        case (cls)
            CL_LD, CL_ST:                 last = 3'd7;
            CL_MULDIV, CL_BR:             last = 3'd6;
            CL_ALU3, CL_ALUI, CL_LDI:     last = 3'd5;
            CL_NEGNOT, CL_JAL:            last = 3'd4;
            default:                      last = 3'd3;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Mini SRC sequencer (fetch T0-T2, class execute T3-T7, HALT); CU_STEP_EN adds single-step
import cu_pkg::*;

module control_unit (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       ir,
    input  logic              con_flag,
    input  logic              stop,
`ifdef CU_STEP_EN
    input  logic              step,
`endif
    output logic [CTRL_W-1:0] ctrl,
    output logic [OPC_W-1:0]  alu_op,
    output logic              run
);

    state_t     state, state_n;
    cls_t       cls;
    logic [2:0] last;
    ctrl_t      ctrl_n;
    logic       single, step_go, exec, fetch, hold;
    logic       unused_ir;

    cu_class_decode u_dec (
        .opc  (ir[31:27]),
        .cls  (cls),
        .last (last)
    );

`ifdef CU_STEP_EN
    assign step_go = step;
    // single is set by a step pulse in HALT and cleared once that instruction drops back to HALT
    always_ff @(posedge clk) begin
        if (!clr) single <= 1'b0;
        else if (state == ST_HALT && step) single <= 1'b1;
        else if (state_n == ST_HALT) single <= 1'b0;
    end
`else
    assign step_go = 1'b0;
    assign single  = 1'b0;
`endif

    assign unused_ir = ^ir[26:0];
    assign fetch     = state inside {ST_T0, ST_T1, ST_T2};
    assign exec      = state inside {ST_T3, ST_T4, ST_T5, ST_T6, ST_T7};
    assign hold      = stop && !single;

    // step register; clr abandons any instruction and restarts at T0
    always_ff @(posedge clk) begin
        if (!clr) state <= ST_T0;
        else state <= state_n;
    end

    // sequencing: stop only checked at T0, class end returns to T0 or HALT
    always_comb begin
        state_n = state;
        case (state)
            ST_HALT: state_n = step_go ? ST_T0 : ST_HALT;
            ST_T0:   state_n = hold ? ST_HALT : ST_T1;
            default: state_n = (exec && state[2:0] == last)
                               ? ((cls == CL_HALT || single) ? ST_HALT : ST_T0)
                               : state_t'(state + 4'd1);
        endcase
    end

    // strobe decode from (state, class); a halting T0 issues nothing so the PC is not advanced
    always_comb begin
        ctrl_n = '0;
        case (state)
            ST_T0: ctrl_n = hold ? '0 : (C_PCOUT | C_MARIN | C_INCPC | C_ZIN);
            ST_T1: ctrl_n = C_ZLOWOUT | C_PCIN | C_READ | C_RAM_READ | C_MDRIN;
            ST_T2: ctrl_n = C_MDROUT | C_IRIN;
            ST_T3: case (cls)
                CL_ALU3, CL_ALUI:     ctrl_n = C_GRB | C_ROUT | C_YIN;
                CL_LD, CL_LDI, CL_ST: ctrl_n = C_GRB | C_ROUT | C_BAOUT | C_YIN;
                CL_MULDIV:            ctrl_n = C_GRA | C_ROUT | C_YIN;
                CL_NEGNOT:            ctrl_n = C_GRB | C_ROUT | C_ZIN;
                CL_BR:                ctrl_n = C_GRA | C_ROUT | C_CONIN;
                CL_JR:                ctrl_n = C_GRA | C_ROUT | C_PCIN;
                CL_JAL:               ctrl_n = C_PCOUT | C_GRB | C_RIN;
                CL_IN:                ctrl_n = C_INPORTOUT | C_GRA | C_RIN;
                CL_OUT:               ctrl_n = C_GRA | C_ROUT | C_OUTPORTIN;
                CL_MFHI:              ctrl_n = C_HIOUT | C_GRA | C_RIN;
                CL_MFLO:              ctrl_n = C_LOOUT | C_GRA | C_RIN;
                CL_ILL:               ctrl_n = C_ILLEGAL;
                default:              ctrl_n = '0;
            endcase
            ST_T4: case (cls)
                CL_ALU3:                       ctrl_n = C_GRC | C_ROUT | C_ZIN;
                CL_ALUI, CL_LD, CL_LDI, CL_ST: ctrl_n = C_COUT | C_ZIN;
                CL_MULDIV:                     ctrl_n = C_GRB | C_ROUT | C_ZIN;
                CL_NEGNOT:                     ctrl_n = C_ZLOWOUT | C_GRA | C_RIN;
                CL_BR:                         ctrl_n = C_PCOUT | C_YIN;
                CL_JAL:                        ctrl_n = C_GRA | C_ROUT | C_PCIN;
                default:                       ctrl_n = '0;
            endcase
            ST_T5: case (cls)
                CL_ALU3, CL_ALUI, CL_LDI: ctrl_n = C_ZLOWOUT | C_GRA | C_RIN;
                CL_LD, CL_ST:             ctrl_n = C_ZLOWOUT | C_MARIN;
                CL_MULDIV:                ctrl_n = C_ZLOWOUT | C_LOIN;
                CL_BR:                    ctrl_n = C_COUT | C_ZIN;
                default:                  ctrl_n = '0;
            endcase
            ST_T6: case (cls)
                CL_LD:     ctrl_n = C_READ | C_RAM_READ | C_MDRIN;
                CL_ST:     ctrl_n = C_GRA | C_ROUT | C_MDRIN;
                CL_MULDIV: ctrl_n = C_ZHIGHOUT | C_HIIN;
                CL_BR:     ctrl_n = con_flag ? (C_ZLOWOUT | C_PCIN) : C_ZLOWOUT;
                default:   ctrl_n = '0;
            endcase
            ST_T7: case (cls)
                CL_LD:   ctrl_n = C_MDROUT | C_GRA | C_RIN;
                CL_ST:   ctrl_n = C_RAM_WRITE;
                default: ctrl_n = '0;
            endcase
            default: ctrl_n = '0;
        endcase
    end

    assign ctrl   = clr ? ctrl_n : '0;
    assign run    = clr && state != ST_HALT;
    assign alu_op = !run ? '0
                  : (fetch || cls inside {CL_LD, CL_LDI, CL_ST, CL_BR}) ? ALU_ADD : ir[31:27];

endmodule
